// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - handshaked RISC-V execute stage with decode and iterative shift-add MUL
module alu_exec_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       func3,
    input  logic             op_5,
    input  logic             func7_5,
    input  logic             func7_0,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       ALUControl,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] C_ADD   = 4'd0;
    localparam logic [3:0] C_SUB   = 4'd1;
    localparam logic [3:0] C_AND   = 4'd2;
    localparam logic [3:0] C_OR    = 4'd3;
    localparam logic [3:0] C_XOR   = 4'd4;
    localparam logic [3:0] C_SLT   = 4'd5;
    localparam logic [3:0] C_SLTU  = 4'd6;
    localparam logic [3:0] C_SLL   = 4'd7;
    localparam logic [3:0] C_SRL   = 4'd8;
    localparam logic [3:0] C_SRA   = 4'd9;
    localparam logic [3:0] C_MUL   = 4'd10;
    localparam logic [3:0] C_PASSB = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mult_a_q, mult_a_d;
    logic [WIDTH-1:0] mult_b_q, mult_b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] addend;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             last_iter;

    always_comb begin
        dec_ctrl = C_ADD;
        case (ALUOp)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            2'b11: dec_ctrl = C_PASSB;
            default: begin
                case (func3)
                    3'b000: begin
                        if (MUL_EN && op_5 && func7_0) begin
                            dec_ctrl = C_MUL;
                        end else if (op_5 && func7_5) begin
                            dec_ctrl = C_SUB;
                        end else begin
                            dec_ctrl = C_ADD;
                        end
                    end
                    3'b001:  dec_ctrl = C_SLL;
                    3'b010:  dec_ctrl = C_SLT;
                    3'b011:  dec_ctrl = C_SLTU;
                    3'b100:  dec_ctrl = C_XOR;
                    3'b101:  dec_ctrl = func7_5 ? C_SRA : C_SRL;
                    3'b110:  dec_ctrl = C_OR;
                    default: dec_ctrl = C_AND;
                endcase
            end
        endcase
    end

    // Single-cycle datapath works on the live operands; they are only sampled on accept.
    always_comb begin
        shamt   = src_b[SHW-1:0];
        alu_out = '0;
        case (dec_ctrl)
            C_ADD:   alu_out = src_a + src_b;
            C_SUB:   alu_out = src_a - src_b;
            C_AND:   alu_out = src_a & src_b;
            C_OR:    alu_out = src_a | src_b;
            C_XOR:   alu_out = src_a ^ src_b;
            C_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            C_SLL:   alu_out = src_a << shamt;
            C_SRL:   alu_out = src_a >> shamt;
            C_SRA:   alu_out = $signed(src_a) >>> shamt;
            C_PASSB: alu_out = src_b;
            default: alu_out = '0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign addend    = mult_b_q[0] ? mult_a_q : '0;
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        acc_d    = acc_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    ctrl_d = dec_ctrl;
                    if (dec_ctrl == C_MUL) begin
                        mult_a_d = src_a;
                        mult_b_d = src_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_CALC;
                    end else begin
                        result_d = alu_out;
                        state_d  = S_DONE;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d    = acc_q + addend;
                mult_a_d = mult_a_q << 1;
                mult_b_d = mult_b_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // The final partial product is folded straight into the result register.
                if (last_iter) begin
                    result_d = acc_q + addend;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_CALC: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= C_ADD;
            result_q <= '0;
            acc_q    <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result     = result_q;
    assign zero       = (result_q == '0);
    assign ALUControl = ctrl_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - self-checking bench for alu_exec_seq against a behavioural model
module tb_alu_exec_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [1:0]    ALUOp;
    logic [2:0]    func3;
    logic          op_5, func7_5, func7_0;
    logic [W-1:0]  src_a, src_b, result;
    logic [3:0]    ALUControl;

    logic          nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready, nm_zero, nm_busy;
    logic [W-1:0]  nm_result;
    logic [3:0]    nm_ctrl;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_exec_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .func3(func3), .op_5(op_5), .func7_5(func7_5), .func7_0(func7_0),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ALUControl(ALUControl), .busy(busy)
    );

    alu_exec_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nm (
        .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .ALUOp(ALUOp), .func3(func3), .op_5(op_5), .func7_5(func7_5), .func7_0(func7_0),
        .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
        .result(nm_result), .zero(nm_zero), .ALUControl(nm_ctrl), .busy(nm_busy)
    );

    // Returns {control code, result} from the instruction fields using plain arithmetic.
    function automatic logic [35:0] model(input logic [1:0] op, input logic [2:0] f3,
                                          input logic o5, input logic f75, input logic f70,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input bit mul_en);
        logic [3:0]         c;
        logic [31:0]        r;
        int                 sh;
        logic signed [63:0] sa;
        logic [63:0]        prod;
        sh = int'(b[4:0]);
        sa = {{32{a[31]}}, a};
        if (op == 2'd0)      c = 4'd0;
        else if (op == 2'd1) c = 4'd1;
        else if (op == 2'd3) c = 4'd11;
        else begin
            case (f3)
                3'd0:    c = (mul_en && o5 && f70) ? 4'd10 : ((o5 && f75) ? 4'd1 : 4'd0);
                3'd1:    c = 4'd7;
                3'd2:    c = 4'd5;
                3'd3:    c = 4'd6;
                3'd4:    c = 4'd4;
                3'd5:    c = f75 ? 4'd9 : 4'd8;
                3'd6:    c = 4'd3;
                default: c = 4'd2;
            endcase
        end
        prod = {32'd0, a} * {32'd0, b};
        case (c)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    r = (a < b) ? 32'd1 : 32'd0;
            4'd7:    r = a << sh;
            4'd8:    r = a >> sh;
            4'd9:    r = 32'(sa >>> sh);
            4'd10:   r = prod[31:0];
            default: r = b;
        endcase
        return {c, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                         input logic f75, input logic f70, input logic [31:0] a, input logic [31:0] b);
        ALUOp = op; func3 = f3; op_5 = o5; func7_5 = f75; func7_0 = f70;
        src_a = a; src_b = b;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic o5, input logic f75, input logic f70,
                          input logic [31:0] a, input logic [31:0] b);
        logic [35:0] m;
        int          lat, bcnt, wt, exp_lat;
        m = model(op, f3, o5, f75, f70, a, b, 1'b1);
        exp_lat = (m[35:32] == 4'd10) ? W + 1 : 1;
        drive(op, f3, o5, f75, f70, a, b);
        in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 200) begin
            step();
            wt++;
        end
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        drive(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        lat = 1;
        bcnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            in_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ":busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        check({tag, ":result"}, 64'(result), 64'(m[31:0]));
        check({tag, ":zero"}, 64'(zero), 64'(m[31:0] == 32'd0));
        check({tag, ":ctrl"}, 64'(ALUControl), 64'(m[35:32]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, exp_bp;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        nm_in_valid = 1'b0;
        nm_out_ready = 1'b1;
        drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) step();
        check("rst:in_ready", 64'(in_ready), 64'd1);
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:result", 64'(result), 64'd0);
        check("rst:zero", 64'(zero), 64'd1);
        check("rst:ctrl", 64'(ALUControl), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();

        run_op("add", 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
        run_op("sub0", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234);
        run_op("slt", 2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        run_op("sltu", 2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        run_op("sra", 2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'h24);
        run_op("srl", 2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h24);
        run_op("mul", 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3);
        check("mul:direct", 64'(result), 64'hFFFFFFFD);

        step();
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3);
        nm_in_valid = 1'b1;
        step();
        nm_in_valid = 1'b0;
        check("nomul:out_valid", 64'(nm_out_valid), 64'd1);
        check("nomul:result", 64'(nm_result), 64'h2);
        check("nomul:ctrl", 64'(nm_ctrl), 64'd0);
        check("nomul:busy", 64'(nm_busy), 64'd0);
        step();

        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        step();

        ra = $urandom | 32'h1;
        rb = ra ^ 32'h00010000;
        exp_bp = ra - rb;
        out_ready = 1'b0;
        run_op("bp_sub", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, ra, rb);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold%0d:result", i), 64'(result), 64'(exp_bp));
            check($sformatf("bp_hold%0d:in_ready", i), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold%0d:out_valid", i), 64'(out_valid), 64'd1);
        end
        drive(2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 32'hF0, 32'h3C);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("b2b_and:out_valid", 64'(out_valid), 64'd1);
        check("b2b_and:result", 64'(result), 64'h30);
        check("b2b_and:ctrl", 64'(ALUControl), 64'd2);
        step();

        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("midmul:busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst:in_ready", 64'(in_ready), 64'd1);
        check("arst:out_valid", 64'(out_valid), 64'd0);
        check("arst:result", 64'(result), 64'd0);
        check("arst:zero", 64'(zero), 64'd1);
        check("arst:ctrl", 64'(ALUControl), 64'd0);
        check("arst:busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        step();
        run_op("post_rst_add", 2'b00, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Parametrised, handshaked execute stage for the multi-cycle RISC-V core.
- Decodes ALUOp/func3/op_5/func7 bits into a 4-bit ALU control code, then executes the operation.
- Single-cycle ops return a registered result; MUL runs as an iterative shift-add over WIDTH cycles.
- Sits between the main decoder/register-file read and the writeback/branch logic.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, 8..64).
- MUL_EN, 1, 1 = decode and execute MUL (func7[0]=1); 0 = MUL encodings fall back to ADD/SUB decode.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 func-decoded, 11 pass B.
- func3  in  3  instruction func3.
- op_5  in  1  opcode bit 5 (1 = R-type).
- func7_5  in  1  func7 bit 5.
- func7_0  in  1  func7 bit 0 (M-extension).
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- ALUControl  out  4  decoded code of the op held in the unit.
- busy  out  1  MUL iteration in progress.

Behaviour:
- Reset (asynchronous, active-high) is the only reset; it has no synchronous term.
- Reset values: state IDLE; in_ready 1; out_valid 0; result 0; zero 1; ALUControl 0000; busy 0.
- ALUControl encoding (low 3 bits compatible with the existing 3-bit code):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT.
  - 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL, 1011 PASSB.
- Decode:
  - ALUOp 00 -> ADD; 01 -> SUB; 11 -> PASSB.
  - ALUOp 10, func3 000: MUL if MUL_EN & op_5 & func7_0; else SUB if op_5 & func7_5; else ADD.
  - ALUOp 10, other func3: 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if func7_5 else SRL, 110 OR, 111 AND.
  - When MUL_EN=0, func7_0 is ignored.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed and SLTU unsigned; both produce 1 or 0, zero-extended.
  - Shift amount = src_b[log2(WIDTH)-1:0]; SRA sign-fills.
  - MUL result = low WIDTH bits of src_a*src_b (sign-agnostic).
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture operands and latch ALUControl. Non-MUL: compute, register result, go to DONE. MUL: clear accumulator and counter, go to CALC.
  - CALC: busy=1, in_ready=0. Each cycle: if mult_b[0], acc += mult_a; mult_a <<= 1; mult_b >>= 1; cnt++. After exactly WIDTH iterations, result<=acc and go to DONE.
  - DONE: out_valid=1; result, zero and ALUControl are held stable. in_ready = out_ready.
    - On out_ready & in_valid: accept the new op in the same cycle (back-to-back, same entry rules as IDLE).
    - On out_ready & !in_valid: go to IDLE.
- Latency, counted from the accept edge to out_valid:
  - Non-MUL: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Boundary conditions:
  - in_valid while busy: ignored, not queued; requester must hold it until in_ready.
  - out_ready held low: unit stalls in DONE indefinitely, outputs unchanged.
  - Reset mid-CALC: aborts immediately, all outputs return to reset values, accumulator discarded.
  - Operand changes after accept: no effect, operands are captured at accept.
  - zero is combinational from the registered result.

Test Plan:
- Reset then ADD: ALUOp=10, func3=000, op_5=1, func7_5=0, src_a=5, src_b=7 -> out_valid one cycle after accept, result=12, ALUControl=0000, zero=0.
- SUB to zero: ALUOp=01, src_a=src_b=0x1234 -> result=0, zero=1, ALUControl=0001. Then SLT with src_a=0xFFFFFFFF, src_b=1 -> result=1; SLTU with same operands -> result=0.
- Shifts with WIDTH=32: SRA src_a=0x80000000, src_b=0x24 (shamt 4) -> 0xF8000000; SRL with same operands -> 0x08000000.
- MUL with MUL_EN=1: src_a=0xFFFFFFFF, src_b=3 -> busy high for 32 cycles, out_valid at cycle 33, result=0xFFFFFFFD. in_valid pulses during CALC are ignored. Same op with MUL_EN=0 -> ADD result=0x00000002 at latency 1.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0 & 0x3C) -> new op accepted that cycle, next result=0x30.
- Reset asserted asynchronously 10 cycles into a MUL -> outputs reset before the next clock edge. An ADD issued after reset release completes normally with latency 1.
